airi5c_itof_pipe: RTL and testbench
===================================

AIRI5C_ITOF_PIPE -- requirements
Module: airi5c_itof_pipe

Interface
REQ-001 SHALL have parameter XLEN, 32, integer operand width; legal values 32 and 64.
REQ-002 SHALL have parameter EXP_W, 8, result exponent width; legal values 8 and 11.
REQ-003 SHALL have parameter MAN_W, 23, result stored-mantissa width; legal values 23 and 52.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port n_reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port kill  input  1  flush all in-flight operations.
REQ-007 SHALL have port in_valid  input  1  an operation is presented.
REQ-008 SHALL have port in_ready  output  1  the operation is accepted this cycle.
REQ-009 SHALL have port op_cvtif  input  1  signed conversion.
REQ-010 SHALL have port op_cvtuf  input  1  unsigned conversion.
REQ-011 SHALL have port rm  input  3  rounding mode: RNE, RTZ, RDN, RUP, RMM encoded 000 to 100.
REQ-012 SHALL have port int_in  input  XLEN  integer operand.
REQ-013 SHALL have port float_out  output  1+EXP_W+MAN_W  IEEE-754 result.
REQ-014 SHALL have port IE  output  1  inexact flag for the current float_out.
REQ-015 SHALL have port out_valid  output  1  float_out and IE are valid.
REQ-016 SHALL have port out_ready  input  1  the consumer takes the result.

Function
REQ-017 SHALL be a two-stage pipeline. S1 does sign/abs, leading-zero count and normalise shift, then registers. S2 does rounding and exponent increment, then registers float_out and IE.
REQ-018 SHALL accept an operation when in_valid && in_ready. Latency from accept to out_valid SHALL be exactly 2 cycles when there is no backpressure.
REQ-019 SHALL compute s2_adv = !s2_valid || out_ready, s1_adv = !s1_valid || s2_adv, and in_ready = s1_adv (combinational from out_ready).
REQ-020 SHALL hold float_out, IE and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL sustain one result per cycle when out_ready stays high.
REQ-022 SHALL give op_cvtif priority when both op bits are set. An accepted operation with neither bit set SHALL be discarded and produce no output.
REQ-023 SHALL derive the sign as int_in[XLEN-1] && op_cvtif and take magnitude = sign ? -int_in : int_in. For a signed minimum the magnitude is 2^(XLEN-1).
REQ-024 SHALL compute exponent = (2^(EXP_W-1)-1) + XLEN-1-lz, then add the rounding carry.
REQ-025 SHALL form the round bit and sticky bit from the bits below the MAN_W mantissa bits. When XLEN-1 <= MAN_W the result SHALL be exact with IE=0.
REQ-026 SHALL output +0 (all zero) with IE=0 for int_in==0, regardless of rm and op.
REQ-027 SHALL treat rm codes 101 to 111 as RNE.
REQ-028 SHALL, on kill, clear s1_valid and s2_valid on the next edge. in_ready SHALL be forced low during the kill cycle, so an operation presented in that cycle is not accepted.

Reset
REQ-029 SHALL, on n_reset low, asynchronously clear all pipeline registers: out_valid=0, float_out=0, IE=0. in_ready SHALL read 1 on the first cycle after release.

Configuration
REQ-030 SHALL, with AIRI5C_ITOF_NX_ACCUM_EN defined, add input clr_nx and output nx_acc. nx_acc SHALL be a sticky OR of IE over every completed handshake, cleared by clr_nx (clear wins over a simultaneous set) and reset to 0.
REQ-031 SHALL, without AIRI5C_ITOF_NX_ACCUM_EN, have neither clr_nx nor nx_acc, and no accumulator register.

Structure
REQ-032 SHALL take rounding-mode encodings and the bias/width helper constants from the shared airi5c FPU package.
REQ-033 SHALL instantiate exactly one new sub-module, airi5c_lzc_param: a leading-zero counter parameterised by width, output width $clog2(XLEN).
REQ-034 SHALL reuse the existing airi5c_rounding_logic with width MAN_W in S2.

Verification
REQ-035 SHALL check default parameters, cvtif, int_in=0xFFFFFFFF, RNE -> 0xBF800000, IE=0, out_valid exactly 2 cycles after accept.
REQ-036 SHALL check cvtuf with 0xFFFFFFFF: RNE -> 0x4F800000, IE=1; RTZ -> 0x4F7FFFFF, IE=1.
REQ-037 SHALL check cvtif with 0x80000000 -> 0xCF000000, IE=0; and cvtif with 0 -> 0x00000000, IE=0.
REQ-038 SHALL check cvtuf with 0x01000001: RNE -> 0x4B800000, IE=1; RUP -> 0x4B800001; RDN -> 0x4B800000.
REQ-039 SHALL check backpressure: 3 back-to-back ops with out_ready=0. in_ready SHALL drop after 2 accepts, outputs SHALL hold stable, and on release results SHALL emerge in order on consecutive cycles.
REQ-040 SHALL check kill with 2 ops in flight: no out_valid afterwards. Also check XLEN=64, EXP_W=11, MAN_W=52 with cvtuf 0xFFFFFFFFFFFFFFFF, RNE -> 0x43F0000000000000, IE=1.

Source files
------------

// File: rtl/airi5c_itof_pipe_pkg.sv
// Shared FPU constants for the integer-to-float pipeline: rounding-mode codes
// and the exponent bias / result-width helpers.
package airi5c_itof_pipe_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    function automatic int unsigned exp_bias(input int unsigned ew);
        return (32'd1 << (ew - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned float_width(input int unsigned ew, input int unsigned mw);
        return 32'd1 + ew + mw;
    endfunction

endpackage

// File: rtl/airi5c_itof_pipe_lzc.sv
// Parameterised leading-zero counter; an all-zero input reports 0, callers
// detect zero separately.
module airi5c_lzc_param #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0]         data_in,
    output logic [$clog2(W)-1:0] lz
);

    localparam int unsigned LZW = $clog2(W);

    logic found;

    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            if (!found && data_in[W-1-i]) begin
                lz    = LZW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/airi5c_rounding_logic.sv
// Mantissa rounding: applies the rounding mode to a truncated mantissa and
// reports the carry out of the mantissa and the inexact condition.
module airi5c_rounding_logic
    import airi5c_itof_pipe_pkg::*;
#(
    parameter int unsigned N = 23
) (
    input  logic [N-1:0] mantissa_in,
    input  logic         sign,
    input  logic         round_bit,
    input  logic         sticky_bit,
    input  logic [2:0]   rm,
    output logic [N-1:0] mantissa_out,
    output logic         carry,
    output logic         inexact
);

    logic round_up;

    always_comb begin
        round_up = 1'b0;
        case (rm)
            RM_RTZ:  round_up = 1'b0;
            RM_RDN:  round_up = (round_bit || sticky_bit) && sign;
            RM_RUP:  round_up = (round_bit || sticky_bit) && !sign;
            RM_RMM:  round_up = round_bit;
            // Reserved codes fall back to round-to-nearest-even.
            default: round_up = round_bit && (sticky_bit || mantissa_in[0]);
        endcase
    end

    assign {carry, mantissa_out} = {1'b0, mantissa_in} + {{N{1'b0}}, round_up};
    assign inexact               = round_bit || sticky_bit;

endmodule

// File: rtl/airi5c_itof_pipe.sv
// Two-stage integer-to-float converter (S1: abs/normalise, S2: round/pack).
// Optional inexact accumulator enabled by AIRI5C_ITOF_NX_ACCUM_EN.
module airi5c_itof_pipe
    import airi5c_itof_pipe_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   kill,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_cvtif,
    input  logic                   op_cvtuf,
    input  logic [2:0]             rm,
    input  logic [XLEN-1:0]        int_in,
    output logic [EXP_W+MAN_W:0]   float_out,
    output logic                   IE,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef AIRI5C_ITOF_NX_ACCUM_EN
    ,
    input  logic                   clr_nx,
    output logic                   nx_acc
`endif
);

    localparam int unsigned LZW     = $clog2(XLEN);
    localparam int unsigned EXP_TOP = exp_bias(EXP_W) + XLEN - 1;
    localparam int unsigned PW      = XLEN - 1 + MAN_W + 2;

    // ---------------- S1: sign, magnitude, normalise ----------------
    logic              s2_adv, s1_adv, accept, op_ok, sign_in;
    logic [XLEN-1:0]   mag, norm;
    logic [LZW-1:0]    lz;

    logic              s1_valid, s1_sign, s1_zero;
    logic [EXP_W-1:0]  s1_exp;
    logic [XLEN-2:0]   s1_frac;
    logic [2:0]        s1_rm;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !kill;
    assign accept   = in_valid && in_ready;

    assign op_ok   = op_cvtif || op_cvtuf;
    assign sign_in = op_cvtif && int_in[XLEN-1];
    assign mag     = sign_in ? (~int_in + 1'b1) : int_in;

    airi5c_lzc_param #(
        .W (XLEN)
    ) u_lzc (
        .data_in (mag),
        .lz      (lz)
    );

    assign norm = mag << lz;

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            s1_valid <= 1'b0;
        else if (kill)
            s1_valid <= 1'b0;
        else if (s1_adv)
            s1_valid <= in_valid && op_ok;
    end

    // A normalised magnitude without its top bit set can only come from zero.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            s1_sign <= 1'b0;
            s1_zero <= 1'b0;
            s1_exp  <= '0;
            s1_frac <= '0;
            s1_rm   <= '0;
        end else if (accept) begin
            s1_sign <= sign_in;
            s1_zero <= !norm[XLEN-1];
            s1_exp  <= EXP_W'(EXP_TOP) - EXP_W'(lz);
            s1_frac <= norm[XLEN-2:0];
            s1_rm   <= rm;
        end
    end

    // ---------------- S2: round and pack ----------------
    logic [PW-1:0]     padded;
    logic [MAN_W-1:0]  mant_trunc, mant_rnd;
    logic              round_bit, sticky_bit, carry, inexact;
    logic [EXP_W-1:0]  res_exp;

    // Zero padding keeps the slicing valid when the fraction is narrower than MAN_W.
    assign padded     = {s1_frac, {(MAN_W + 2){1'b0}}};
    assign mant_trunc = padded[PW-1 -: MAN_W];
    assign round_bit  = padded[PW-1-MAN_W];
    assign sticky_bit = |padded[PW-MAN_W-2:0];

    airi5c_rounding_logic #(
        .N (MAN_W)
    ) u_round (
        .mantissa_in  (mant_trunc),
        .sign         (s1_sign),
        .round_bit    (round_bit),
        .sticky_bit   (sticky_bit),
        .rm           (s1_rm),
        .mantissa_out (mant_rnd),
        .carry        (carry),
        .inexact      (inexact)
    );

    assign res_exp = s1_exp + EXP_W'(carry);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid <= 1'b0;
            float_out <= '0;
            IE        <= 1'b0;
        end else begin
            if (kill)
                out_valid <= 1'b0;
            else if (s2_adv)
                out_valid <= s1_valid;

            if (s2_adv && s1_valid && !kill) begin
                float_out <= s1_zero ? '0 : {s1_sign, res_exp, mant_rnd};
                IE        <= !s1_zero && inexact;
            end
        end
    end

`ifdef AIRI5C_ITOF_NX_ACCUM_EN
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset)
            nx_acc <= 1'b0;
        else if (clr_nx)
            nx_acc <= 1'b0;
        else if (out_valid && out_ready)
            nx_acc <= nx_acc | IE;
    end
`endif

endmodule

// File: tb/tb_airi5c_itof_pipe.sv
// Directed bench for airi5c_itof_pipe: 32-bit single and 64-bit double instances.
module tb_airi5c_itof_pipe;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        kill = 1'b0;

    logic        in_valid = 1'b0, op_cvtif = 1'b0, op_cvtuf = 1'b0, out_ready = 1'b1;
    logic [2:0]  rm = 3'b000;
    logic [31:0] int_in = '0;
    logic        in_ready, IE, out_valid;
    logic [31:0] float_out;

    logic        in_valid64 = 1'b0, op_cvtuf64 = 1'b0;
    logic [63:0] int_in64 = '0;
    logic        in_ready64, IE64, out_valid64;
    logic [63:0] float_out64;

`ifdef AIRI5C_ITOF_NX_ACCUM_EN
    logic clr_nx = 1'b0, clr_nx64 = 1'b0, nx_acc, nx_acc64;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    airi5c_itof_pipe #(.XLEN(32), .EXP_W(8), .MAN_W(23)) dut32 (
        .clk       (clk),
        .n_reset   (n_reset),
        .kill      (kill),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_cvtif  (op_cvtif),
        .op_cvtuf  (op_cvtuf),
        .rm        (rm),
        .int_in    (int_in),
        .float_out (float_out),
        .IE        (IE),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef AIRI5C_ITOF_NX_ACCUM_EN
        ,
        .clr_nx    (clr_nx),
        .nx_acc    (nx_acc)
`endif
    );

    airi5c_itof_pipe #(.XLEN(64), .EXP_W(11), .MAN_W(52)) dut64 (
        .clk       (clk),
        .n_reset   (n_reset),
        .kill      (kill),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .op_cvtif  (1'b0),
        .op_cvtuf  (op_cvtuf64),
        .rm        (3'b000),
        .int_in    (int_in64),
        .float_out (float_out64),
        .IE        (IE64),
        .out_valid (out_valid64),
        .out_ready (1'b1)
`ifdef AIRI5C_ITOF_NX_ACCUM_EN
        ,
        .clr_nx    (clr_nx64),
        .nx_acc    (nx_acc64)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op with no backpressure and check the 2-cycle latency and result.
    task automatic convert(input string tag, input logic cvtif, input logic cvtuf,
                           input logic [2:0] r, input logic [31:0] v,
                           input logic [31:0] exp_f, input logic exp_ie);
        op_cvtif  = cvtif;
        op_cvtuf  = cvtuf;
        rm        = r;
        int_in    = v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check({tag, ".lat1"}, 64'(out_valid), 64'd0);
        tick();
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".float"}, 64'(float_out), 64'(exp_f));
        check({tag, ".IE"}, 64'(IE), 64'(exp_ie));
    endtask

    task automatic present(input logic [31:0] v);
        op_cvtif = 1'b0;
        op_cvtuf = 1'b1;
        rm       = 3'b000;
        int_in   = v;
        in_valid = 1'b1;
    endtask

    initial begin
        #2;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.float_out", 64'(float_out), 64'd0);
        check("rst.IE", 64'(IE), 64'd0);
        #10 n_reset = 1'b1;
        tick();
        check("rst.in_ready", 64'(in_ready), 64'd1);

        convert("if_m1",      1'b1, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0);
        convert("uf_max_rne", 1'b0, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'h4F80_0000, 1'b1);
`ifdef AIRI5C_ITOF_NX_ACCUM_EN
        tick();
        check("nx_acc.set", 64'(nx_acc), 64'd1);
        clr_nx = 1'b1;
        tick();
        clr_nx = 1'b0;
        check("nx_acc.clr", 64'(nx_acc), 64'd0);
`endif
        convert("uf_max_rtz", 1'b0, 1'b1, 3'b001, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 1'b1);
        convert("if_min",     1'b1, 1'b0, 3'b000, 32'h8000_0000, 32'hCF00_0000, 1'b0);
        convert("if_zero",    1'b1, 1'b0, 3'b000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        convert("uf_zero_rup", 1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'h0000_0000, 1'b0);
        convert("tie_rne",    1'b0, 1'b1, 3'b000, 32'h0100_0001, 32'h4B80_0000, 1'b1);
        convert("tie_rup",    1'b0, 1'b1, 3'b011, 32'h0100_0001, 32'h4B80_0001, 1'b1);
        convert("tie_rdn",    1'b0, 1'b1, 3'b010, 32'h0100_0001, 32'h4B80_0000, 1'b1);
        convert("tie_rmm",    1'b0, 1'b1, 3'b100, 32'h0100_0001, 32'h4B80_0001, 1'b1);
        convert("tie_rm7",    1'b0, 1'b1, 3'b111, 32'h0100_0001, 32'h4B80_0000, 1'b1);
        convert("neg_rdn",    1'b1, 1'b0, 3'b010, 32'hFEFF_FFFF, 32'hCB80_0001, 1'b1);
        convert("neg_rup",    1'b1, 1'b0, 3'b011, 32'hFEFF_FFFF, 32'hCB80_0000, 1'b1);
        convert("both_ops",   1'b1, 1'b1, 3'b000, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0);
        convert("uf_three",   1'b0, 1'b1, 3'b000, 32'h0000_0003, 32'h4040_0000, 1'b0);

        // Neither op bit: accepted but produces nothing.
        op_cvtif = 1'b0;
        op_cvtuf = 1'b0;
        int_in   = 32'h1234_5678;
        in_valid = 1'b1;
        #1;
        check("noop.in_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        check("noop.valid1", 64'(out_valid), 64'd0);
        tick();
        check("noop.valid2", 64'(out_valid), 64'd0);

        // Backpressure: three ops, consumer stalled.
        out_ready = 1'b0;
        present(32'd1);
        #1;
        check("bp.acc1", 64'(in_ready), 64'd1);
        tick();
        present(32'd2);
        check("bp.acc2", 64'(in_ready), 64'd1);
        tick();
        present(32'd3);
        check("bp.stall", 64'(in_ready), 64'd0);
        check("bp.valid", 64'(out_valid), 64'd1);
        check("bp.first", 64'(float_out), 64'h3F80_0000);
        tick();
        check("bp.hold_rdy", 64'(in_ready), 64'd0);
        check("bp.hold_val", 64'(out_valid), 64'd1);
        check("bp.hold_f", 64'(float_out), 64'h3F80_0000);
        check("bp.hold_ie", 64'(IE), 64'd0);
        out_ready = 1'b1;
        #1;
        check("bp.release", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp.r2_val", 64'(out_valid), 64'd1);
        check("bp.r2", 64'(float_out), 64'h4000_0000);
        tick();
        check("bp.r3_val", 64'(out_valid), 64'd1);
        check("bp.r3", 64'(float_out), 64'h4040_0000);
        tick();
        check("bp.drain", 64'(out_valid), 64'd0);

        // Kill with two ops in flight; an op offered during kill is refused.
        out_ready = 1'b0;
        present(32'd5);
        tick();
        present(32'd6);
        tick();
        present(32'd7);
        kill = 1'b1;
        #1;
        check("kill.in_ready", 64'(in_ready), 64'd0);
        tick();
        kill      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("kill.valid0", 64'(out_valid), 64'd0);
        tick();
        check("kill.valid1", 64'(out_valid), 64'd0);
        tick();
        check("kill.valid2", 64'(out_valid), 64'd0);

        // Double-precision instance.
        op_cvtuf64 = 1'b1;
        int_in64   = 64'hFFFF_FFFF_FFFF_FFFF;
        in_valid64 = 1'b1;
        #1;
        check("d64.in_ready", 64'(in_ready64), 64'd1);
        tick();
        in_valid64 = 1'b0;
        check("d64.lat1", 64'(out_valid64), 64'd0);
        tick();
        check("d64.valid", 64'(out_valid64), 64'd1);
        check("d64.float", float_out64, 64'h43F0_0000_0000_0000);
        check("d64.IE", 64'(IE64), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
